snake_frame_scheduler: RTL

- Paces game-state updates to the display frame rate and double-buffers the snake and food coordinates.
- Coordinates change only at the start of vertical sync, so the VGA renderer never draws a half-updated snake within one frame.
- Sits between the game logic, which computes the next snake/food positions, and the VGA controller, which consumes the packed snake X/Y and food X/Y buses.
- Issues a step request to the game logic every N frames, and supports a runtime speed-up and pause.

---
 rtl/snake_frame_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/snake_frame_scheduler.sv
// snake_frame_scheduler
//
// Paces game-state updates to the display frame rate and double-buffers the
// snake and food coordinates. New coordinates from the game logic are held in
// shadow registers and only reach the display outputs on a falling VSync
// edge, so the renderer never sees a partially updated snake within a frame.
//
// Ports:
//   Clock       pixel clock (same domain as the VGA controller)
//   Reset       synchronous, active-high
//   VSync       VGA vertical sync, active low
//   pause       level; freezes frame pacing
//   speedUp     one-cycle pulse; shortens the step period by one frame
//   stepReq     request to the game logic for the next step
//   stepAck     one-cycle pulse; in* buses are valid in the same cycle
//   inSnakeY/X  next packed snake coordinates
//   inFoodY/X   next food coordinates
//   packSnakeY/X, foodY/X   displayed coordinates, to the VGA controller
//   stepDone    one-cycle pulse after a commit to the display registers
//   overrun     one-cycle pulse after a step was dropped
//   period      current frames-per-step
module snake_frame_scheduler #(
  parameter int numSnakePieces   = 4,
  parameter int yCoordBits       = 5,
  parameter int xCoordBits       = 6,
  parameter int framesPerStep    = 6,
  parameter int minFramesPerStep = 2
) (
  input  logic                                   Clock,
  input  logic                                   Reset,
  input  logic                                   VSync,
  input  logic                                   pause,
  input  logic                                   speedUp,
  output logic                                   stepReq,
  input  logic                                   stepAck,
  input  logic [yCoordBits*numSnakePieces-1:0]   inSnakeY,
  input  logic [xCoordBits*numSnakePieces-1:0]   inSnakeX,
  input  logic [yCoordBits-1:0]                  inFoodY,
  input  logic [xCoordBits-1:0]                  inFoodX,
  output logic [yCoordBits*numSnakePieces-1:0]   packSnakeY,
  output logic [xCoordBits*numSnakePieces-1:0]   packSnakeX,
  output logic [yCoordBits-1:0]                  foodY,
  output logic [xCoordBits-1:0]                  foodX,
  output logic                                   stepDone,
  output logic                                   overrun,
  output logic [5:0]                             period
);

  localparam logic [5:0] PERIOD_RST = 6'(framesPerStep);
  localparam logic [5:0] PERIOD_MIN = 6'(minFramesPerStep);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_VB = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic       prevVSync;
  logic       vsFall;
  logic [5:0] frameCnt;
  logic [5:0] cntNext;
  logic [5:0] periodNext;
  logic       expire;

  logic       capture_p0;
  logic       commit_p0;
  logic       drop_p0;

  logic [yCoordBits*numSnakePieces-1:0] shadowSnakeY;
  logic [xCoordBits*numSnakePieces-1:0] shadowSnakeX;
  logic [yCoordBits-1:0]                shadowFoodY;
  logic [xCoordBits-1:0]                shadowFoodX;

  // Period decrement that never drops below the configured floor.
  function automatic logic [5:0] sat_dec(input logic [5:0] p);
    if (p > PERIOD_MIN)
      return p - 6'd1;
    else
      return PERIOD_MIN;
  endfunction

  assign vsFall = prevVSync & ~VSync;

  // Frame pacing: expire marks the frame on which a new step is due.
  always_comb begin
    expire     = 1'b0;
    cntNext    = frameCnt;
    periodNext = period;
    if (vsFall && !pause) begin
      if (frameCnt == period - 6'd1) begin
        expire  = 1'b1;
        cntNext = '0;
      end else begin
        cntNext = frameCnt + 6'd1;
      end
    end
    if (speedUp) begin
      periodNext = sat_dec(period);
      // Keep the counter inside the shortened period so it still wraps.
      if (cntNext >= periodNext)
        cntNext = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prevVSync <= 1'b1;
      frameCnt  <= '0;
      period    <= PERIOD_RST;
    end else begin
      prevVSync <= VSync;
      frameCnt  <= cntNext;
      period    <= periodNext;
    end
  end

  // Step handshake state register.
  always_ff @(posedge Clock) begin
    if (Reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (expire)
          stateNext = REQ;
      end
      REQ: begin
        if (stepAck)
          stateNext = WAIT_VB;
      end
      WAIT_VB: begin
        if (vsFall)
          stateNext = expire ? REQ : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    stepReq    = (state == REQ);
    capture_p0 = (state == REQ) && stepAck;
    drop_p0    = (state == REQ) && expire;
    commit_p0  = (state == WAIT_VB) && vsFall;
  end

  // p0 -> p1: shadow capture, display commit and status pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadowSnakeY <= '0;
      shadowSnakeX <= '0;
      shadowFoodY  <= '0;
      shadowFoodX  <= '0;
      packSnakeY   <= '0;
      packSnakeX   <= '0;
      foodY        <= '0;
      foodX        <= '0;
      stepDone     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (capture_p0) begin
        shadowSnakeY <= inSnakeY;
        shadowSnakeX <= inSnakeX;
        shadowFoodY  <= inFoodY;
        shadowFoodX  <= inFoodX;
      end
      if (commit_p0) begin
        packSnakeY <= shadowSnakeY;
        packSnakeX <= shadowSnakeX;
        foodY      <= shadowFoodY;
        foodX      <= shadowFoodX;
      end
      stepDone <= commit_p0;
      overrun  <= drop_p0;
    end
  end

endmodule
